// File: rtl/dp_tcdm_rr_mux_pkg.sv
// Shared types for the dot-product TCDM request multiplexer.
// dp_mux_ctrl_t is embedded in the streamer control struct; its sel field
// is sized for the default of four requesters per master port.
package dp_tcdm_rr_mux_pkg;

  typedef enum logic {
    DP_MUX_RR     = 1'b0,
    DP_MUX_STATIC = 1'b1
  } dp_mux_mode_e;

  typedef enum logic {
    MUX_IDLE   = 1'b0,
    MUX_LOCKED = 1'b1
  } dp_mux_state_e;

  localparam int unsigned DP_MUX_SEL_W = 2;

  typedef struct packed {
    dp_mux_mode_e            mode;
    logic [DP_MUX_SEL_W-1:0] sel;
  } dp_mux_ctrl_t;

  // 32-bit increment that sticks at all-ones instead of wrapping
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    if (v == 32'hFFFF_FFFF) begin
      return v;
    end else begin
      return v + 32'd1;
    end
  endfunction

endpackage

// File: rtl/dp_tcdm_rr_mux_id_fifo.sv
// In-order requester-ID FIFO: one entry per transaction awaiting r_valid.
// Push is ignored when full and pop is ignored when empty, so the owner
// can drive raw strobes; simultaneous push+pop advances both pointers.
module dp_id_fifo #(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned WIDTH = 2,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             push_s;
  logic             pop_s;

  // Pointer advance with wrap at DEPTH-1 (DEPTH need not be a power of two)
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PW'(1);
    end
  endfunction

  assign full_o  = (count_r == CW'(DEPTH));
  assign empty_o = (count_r == CW'(0));
  assign push_s  = push_i & ~full_o;
  assign pop_s   = pop_i & ~empty_o;
  assign data_o  = mem_r[rd_ptr_r];
  assign count_o = count_r;

  // Storage, pointers and occupancy
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_r[i] <= '0;
    end else if (clear_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= data_i;
        wr_ptr_r        <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) rd_ptr_r <= ptr_inc(rd_ptr_r);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/dp_tcdm_rr_mux.sv
// N_IN-to-1 TCDM request multiplexer for the dot-product streamer.
// Round-robin or static selection, request locked to its winner until
// granted, and an in-order ID FIFO that steers each r_valid back to the
// requester that issued it.
// Optional feature macro: DP_TCDM_MUX_PERF_EN enables the saturating
// grant/stall counters; without it perf_gnt_o/perf_stall_o read 0.
module dp_tcdm_rr_mux
  import dp_tcdm_rr_mux_pkg::*;
#(
  parameter  int unsigned N_IN            = 4,
  parameter  int unsigned AW              = 32,
  parameter  int unsigned DW              = 32,
  parameter  int unsigned MAX_OUTSTANDING = 4,
  localparam int unsigned IW              = $clog2(N_IN),
  localparam int unsigned BW              = DW / 8,
  localparam int unsigned CW              = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clear_i,
  input  logic                     enable_i,
  input  dp_mux_mode_e             mode_i,
  input  logic [IW-1:0]            sel_i,
  input  logic [N_IN-1:0]          in_req_i,
  output logic [N_IN-1:0]          in_gnt_o,
  input  logic [N_IN-1:0][AW-1:0]  in_add_i,
  input  logic [N_IN-1:0]          in_wen_i,
  input  logic [N_IN-1:0][BW-1:0]  in_be_i,
  input  logic [N_IN-1:0][DW-1:0]  in_data_i,
  output logic [DW-1:0]            in_r_data_o,
  output logic [N_IN-1:0]          in_r_valid_o,
  output logic                     out_req_o,
  output logic [AW-1:0]            out_add_o,
  output logic                     out_wen_o,
  output logic [BW-1:0]            out_be_o,
  output logic [DW-1:0]            out_data_o,
  input  logic                     out_gnt_i,
  input  logic [DW-1:0]            out_r_data_i,
  input  logic                     out_r_valid_i,
  output logic                     busy_o,
  output logic                     err_o,
  output logic [31:0]              perf_gnt_o,
  output logic [31:0]              perf_stall_o
);

  dp_mux_state_e state_r, state_s;
  logic [IW-1:0] rr_r;
  logic [IW-1:0] win_r;
  logic          lock_rr_r;
  logic          err_r;

  logic          win_valid_s;
  logic [IW-1:0] win_idx_s;
  logic [IW-1:0] cand_s;
  logic          drive_valid_s;
  logic [IW-1:0] drive_idx_s;
  logic          drive_rr_s;
  logic          hs_s;
  logic          pop_s;

  logic [IW-1:0] fifo_head_s;
  logic          fifo_full_s;
  logic          fifo_empty_s;
  logic [CW-1:0] fifo_count_s;

  // Candidate winner from the live request vector under the selected mode
  always_comb begin
    win_valid_s = 1'b0;
    win_idx_s   = '0;
    cand_s      = '0;
    if (mode_i == DP_MUX_RR) begin
      for (int k = 0; k < int'(N_IN); k++) begin
        cand_s = IW'((int'(rr_r) + k) % int'(N_IN));
        if (!win_valid_s && in_req_i[cand_s]) begin
          win_valid_s = 1'b1;
          win_idx_s   = cand_s;
        end else begin
          win_valid_s = win_valid_s;
        end
      end
    end else begin
      if ((int'(sel_i) < int'(N_IN)) && in_req_i[sel_i]) begin
        win_valid_s = 1'b1;
        win_idx_s   = sel_i;
      end else begin
        win_valid_s = 1'b0;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= MUX_IDLE;
    end else if (clear_i) begin
      state_r <= MUX_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next state: an ungranted request locks until its grant arrives
  always_comb begin
    state_s = state_r;
    case (state_r)
      MUX_IDLE: begin
        if (drive_valid_s && !out_gnt_i) state_s = MUX_LOCKED;
        else                             state_s = MUX_IDLE;
      end
      MUX_LOCKED: begin
        if (out_gnt_i) state_s = MUX_IDLE;
        else           state_s = MUX_LOCKED;
      end
      default: state_s = MUX_IDLE;
    endcase
  end

  // FSM outputs: which requester drives the master port this cycle
  always_comb begin
    drive_valid_s = 1'b0;
    drive_idx_s   = '0;
    drive_rr_s    = 1'b0;
    case (state_r)
      MUX_IDLE: begin
        // Full is judged on the registered count: no r_valid -> req path
        drive_valid_s = enable_i & ~fifo_full_s & win_valid_s;
        drive_idx_s   = win_idx_s;
        drive_rr_s    = (mode_i == DP_MUX_RR);
      end
      MUX_LOCKED: begin
        drive_valid_s = 1'b1;
        drive_idx_s   = win_r;
        drive_rr_s    = lock_rr_r;
      end
      default: begin
        drive_valid_s = 1'b0;
      end
    endcase
  end

  assign hs_s  = drive_valid_s & out_gnt_i;
  assign pop_s = out_r_valid_i & ~fifo_empty_s;

  // Locked winner capture and round-robin pointer advance on handshake
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_r      <= '0;
      win_r     <= '0;
      lock_rr_r <= 1'b0;
    end else if (clear_i) begin
      rr_r      <= '0;
      win_r     <= '0;
      lock_rr_r <= 1'b0;
    end else begin
      if (state_r == MUX_IDLE && drive_valid_s && !out_gnt_i) begin
        win_r     <= drive_idx_s;
        lock_rr_r <= drive_rr_s;
      end
      if (hs_s && drive_rr_s) begin
        rr_r <= (drive_idx_s == IW'(N_IN - 1)) ? '0 : drive_idx_s + IW'(1);
      end
    end
  end

  // Request forwarding, zeroed while no request is driven
  assign out_req_o  = drive_valid_s;
  assign out_add_o  = drive_valid_s ? in_add_i[drive_idx_s]  : '0;
  assign out_wen_o  = drive_valid_s ? in_wen_i[drive_idx_s]  : 1'b0;
  assign out_be_o   = drive_valid_s ? in_be_i[drive_idx_s]   : '0;
  assign out_data_o = drive_valid_s ? in_data_i[drive_idx_s] : '0;

  // Grant to the driving requester and response valid to the FIFO head
  always_comb begin
    in_gnt_o     = '0;
    in_r_valid_o = '0;
    for (int i = 0; i < int'(N_IN); i++) begin
      in_gnt_o[i]     = hs_s & (drive_idx_s == IW'(i));
      in_r_valid_o[i] = pop_s & (fifo_head_s == IW'(i));
    end
  end

  assign in_r_data_o = out_r_data_i;
  assign busy_o      = (fifo_count_s != CW'(0)) | (state_r == MUX_LOCKED);
  assign err_o       = err_r;

  dp_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (IW)
  ) i_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (clear_i),
    .push_i  (hs_s),
    .data_i  (drive_idx_s),
    .pop_i   (pop_s),
    .data_o  (fifo_head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .count_o (fifo_count_s)
  );

  // Sticky flag for a response arriving with nothing outstanding
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_r <= 1'b0;
    end else if (clear_i) begin
      err_r <= 1'b0;
    end else if (out_r_valid_i && fifo_empty_s) begin
      err_r <= 1'b1;
    end
  end

`ifdef DP_TCDM_MUX_PERF_EN
  logic [31:0] perf_gnt_r;
  logic [31:0] perf_stall_r;

  // Saturating handshake and stall counters
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_gnt_r   <= 32'd0;
      perf_stall_r <= 32'd0;
    end else if (clear_i) begin
      perf_gnt_r   <= 32'd0;
      perf_stall_r <= 32'd0;
    end else begin
      if (hs_s) perf_gnt_r <= sat_inc32(perf_gnt_r);
      if (drive_valid_s && !out_gnt_i) perf_stall_r <= sat_inc32(perf_stall_r);
    end
  end

  assign perf_gnt_o   = perf_gnt_r;
  assign perf_stall_o = perf_stall_r;
`else
  assign perf_gnt_o   = 32'd0;
  assign perf_stall_o = 32'd0;
`endif

endmodule

// File: tb/tb_dp_tcdm_rr_mux.sv
// Self-checking bench for dp_tcdm_rr_mux (N_IN=4, MAX_OUTSTANDING=2).
// A queue-based reference model predicts every output each cycle; directed
// sequences pin the model with hand-computed literals, then random traffic
// runs against the model.
module tb_dp_tcdm_rr_mux;
  import dp_tcdm_rr_mux_pkg::*;

  localparam int N    = 4;
  localparam int MAXO = 2;

  logic                clk = 1'b0;
  logic                rst, clear, enable;
  dp_mux_mode_e        mode;
  logic [1:0]          sel;
  logic [3:0]          in_req, in_gnt, in_wen, in_r_valid;
  logic [3:0][31:0]    in_add, in_data;
  logic [3:0][3:0]     in_be;
  logic [31:0]         in_r_data, out_add, out_data, out_r_data;
  logic                out_req, out_wen, out_gnt, out_r_valid, busy, err;
  logic [3:0]          out_be;
  logic [31:0]         perf_gnt, perf_stall;

  int total = 0;
  int bad   = 0;

  // reference model state
  int          m_rr;
  bit          m_locked;
  int          m_lidx;
  bit          m_lrr;
  bit          m_err;
  int          m_q[$];
  int unsigned m_pg, m_ps;

  logic [3:0] rr_g  [5] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
  logic [3:0] rr_rv [5] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8};

  dp_tcdm_rr_mux #(.N_IN(N), .AW(32), .DW(32), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .enable_i(enable),
    .mode_i(mode), .sel_i(sel), .in_req_i(in_req), .in_gnt_o(in_gnt),
    .in_add_i(in_add), .in_wen_i(in_wen), .in_be_i(in_be), .in_data_i(in_data),
    .in_r_data_o(in_r_data), .in_r_valid_o(in_r_valid),
    .out_req_o(out_req), .out_add_o(out_add), .out_wen_o(out_wen),
    .out_be_o(out_be), .out_data_o(out_data), .out_gnt_i(out_gnt),
    .out_r_data_i(out_r_data), .out_r_valid_i(out_r_valid),
    .busy_o(busy), .err_o(err), .perf_gnt_o(perf_gnt), .perf_stall_o(perf_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rr = 0; m_locked = 0; m_lidx = 0; m_lrr = 0; m_err = 0;
    m_q.delete(); m_pg = 0; m_ps = 0;
  endtask

  // At the falling edge: predict outputs from model + inputs, compare, then
  // advance the model to what the coming rising edge commits.
  task automatic cyc();
    bit dv, frr;
    int drv;
    logic [3:0] eg, erv;
    @(negedge clk);
    dv = 0; drv = 0; frr = 0;
    if (m_locked) begin
      dv = 1; drv = m_lidx; frr = m_lrr;
    end else begin
      frr = (mode == DP_MUX_RR);
      if (enable && m_q.size() < MAXO) begin
        if (mode == DP_MUX_RR) begin
          for (int k = 0; k < N; k++) begin
            if (!dv && in_req[(m_rr + k) % N]) begin
              dv = 1; drv = (m_rr + k) % N;
            end
          end
        end else if (int'(sel) < N && in_req[sel]) begin
          dv = 1; drv = int'(sel);
        end
      end
    end
    eg  = (dv && out_gnt) ? 4'(1 << drv) : 4'h0;
    erv = (out_r_valid && m_q.size() > 0) ? 4'(1 << m_q[0]) : 4'h0;
    chk("out_req",   out_req, dv);
    chk("out_add",   out_add,  dv ? in_add[drv]  : 32'h0);
    chk("out_wen",   out_wen,  dv ? in_wen[drv]  : 1'b0);
    chk("out_be",    out_be,   dv ? in_be[drv]   : 4'h0);
    chk("out_data",  out_data, dv ? in_data[drv] : 32'h0);
    chk("in_gnt",    in_gnt, eg);
    chk("in_rvalid", in_r_valid, erv);
    chk("in_rdata",  in_r_data, out_r_data);
    chk("busy",      busy, (m_q.size() != 0) || m_locked);
    chk("err",       err, m_err);
`ifdef DP_TCDM_MUX_PERF_EN
    chk("perf_gnt",   perf_gnt, m_pg);
    chk("perf_stall", perf_stall, m_ps);
`else
    chk("perf_gnt",   perf_gnt, 32'h0);
    chk("perf_stall", perf_stall, 32'h0);
`endif
    if (clear) begin
      model_reset();
    end else begin
      if (out_r_valid) begin
        if (m_q.size() > 0) void'(m_q.pop_front());
        else m_err = 1;
      end
      if (dv && out_gnt) begin
        m_q.push_back(drv);
        if (frr) m_rr = (drv + 1) % N;
        m_locked = 0;
        m_pg++;
      end else if (dv) begin
        m_locked = 1; m_lidx = drv; m_lrr = frr;
        m_ps++;
      end
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    in_req = 4'h0; out_gnt = 1'b0; out_r_valid = 1'b0; clear = 1'b0;
  endtask

  task automatic do_clear();
    idle_in(); clear = 1'b1; cyc(); nxt(); clear = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; mode = DP_MUX_RR; sel = 2'd0;
    idle_in(); out_r_data = 32'h0;
    for (int i = 0; i < N; i++) begin
      in_add[i]  = 32'hA000_0000 + 32'(i);
      in_data[i] = 32'hD000_0000 + 32'(i);
      in_wen[i]  = 1'(i);
      in_be[i]   = 4'(i + 1);
    end
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    cyc();
    chk("rst_req", out_req, 1'b0); chk("rst_gnt", in_gnt, 4'h0);
    chk("rst_busy", busy, 1'b0);   chk("rst_err", err, 1'b0);
    chk("rst_rvalid", in_r_valid, 4'h0);
    nxt();

    // round robin, all requesting, responses one cycle after grant
    for (int c = 0; c < 5; c++) begin
      in_req = 4'hF; out_gnt = 1'b1; out_r_valid = (c > 0); out_r_data = $urandom;
      cyc();
      chk("rr_gnt", in_gnt, rr_g[c]); chk("rr_rvalid", in_r_valid, rr_rv[c]);
      nxt();
    end
    idle_in(); out_r_valid = 1'b1; cyc(); chk("rr_drain", in_r_valid, 4'h1); nxt();
    do_clear();

    // lock while stalled: requester 1 holds the port, 0 arrives meanwhile
    for (int c = 0; c < 3; c++) begin
      in_req = (c == 0) ? 4'h2 : 4'h3; out_gnt = 1'b0;
      cyc();
      chk("lock_add", out_add, 32'hA000_0001);
      if (c > 0) chk("lock_busy", busy, 1'b1);
      nxt();
    end
    out_gnt = 1'b1; cyc(); chk("lock_gnt", in_gnt, 4'h2); nxt();
    cyc(); chk("lock_next", in_gnt, 4'h1); nxt();
    idle_in(); out_r_valid = 1'b1;
    cyc(); chk("lock_rv0", in_r_valid, 4'h2); nxt();
    cyc(); chk("lock_rv1", in_r_valid, 4'h1); nxt();
    do_clear();

    // outstanding limit of two
    in_req = 4'hF; out_gnt = 1'b1;
    cyc(); chk("full_g0", in_gnt, 4'h1); nxt();
    cyc(); chk("full_g1", in_gnt, 4'h2); nxt();
    cyc(); chk("full_block", out_req, 1'b0); nxt();
    out_r_valid = 1'b1;
    cyc(); chk("full_pop_block", out_req, 1'b0); chk("full_rv", in_r_valid, 4'h1); nxt();
    out_r_valid = 1'b0;
    cyc(); chk("full_resume", in_gnt, 4'h4); nxt();
    idle_in(); out_r_valid = 1'b1;
    cyc(); chk("full_d0", in_r_valid, 4'h2); nxt();
    cyc(); chk("full_d1", in_r_valid, 4'h4); nxt();
    do_clear();

    // static selection
    mode = DP_MUX_STATIC; sel = 2'd2; in_req = 4'h5; out_gnt = 1'b1;
    cyc(); chk("st_gnt", in_gnt, 4'h4); nxt();
    in_req = 4'h1;
    cyc(); chk("st_none", out_req, 1'b0); nxt();
    idle_in(); out_r_valid = 1'b1;
    cyc(); chk("st_rv", in_r_valid, 4'h4); nxt();
    mode = DP_MUX_RR;

    // stray response
    cyc(); chk("err_rv", in_r_valid, 4'h0); nxt();
    out_r_valid = 1'b0;
    cyc(); chk("err_set", err, 1'b1); nxt();
    do_clear();
    cyc(); chk("err_clr", err, 1'b0); nxt();

    // five stall cycles then a grant
    in_req = 4'h1; out_gnt = 1'b0;
    repeat (5) begin cyc(); nxt(); end
    out_gnt = 1'b1; cyc(); nxt();
    idle_in(); out_r_valid = 1'b1; cyc();
`ifdef DP_TCDM_MUX_PERF_EN
    chk("perf_stall5", perf_stall, 32'd5); chk("perf_gnt1", perf_gnt, 32'd1);
`else
    chk("perf_stall0", perf_stall, 32'd0); chk("perf_gnt0", perf_gnt, 32'd0);
`endif
    nxt();
    idle_in();

    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0) mode = dp_mux_mode_e'($urandom_range(0, 1));
      sel = 2'($urandom_range(0, 3));
      for (int i = 0; i < N; i++) begin
        in_req[i]  = ($urandom_range(0, 2) != 0);
        in_add[i]  = $urandom;
        in_data[i] = $urandom;
        in_wen[i]  = 1'($urandom);
        in_be[i]   = 4'($urandom);
      end
      if (m_locked) in_req[m_lidx] = 1'b1;
      out_gnt     = 1'($urandom_range(0, 1));
      out_r_valid = (m_q.size() > 0) && ($urandom_range(0, 2) != 0);
      out_r_data  = $urandom;
      clear       = (!m_locked && m_q.size() == 0 && $urandom_range(0, 99) == 0);
      cyc();
      nxt();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
